// File: rtl/btn_step_pkg.sv
// Shared definitions for the button step generator: FSM state encodings,
// direction constants and a small parameter helper.
package btn_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button 2-flop synchroniser followed by a stability counter. The
// debounced level only follows the synchronised input after it has differed
// from the current level for DEB_CYCLES consecutive samples.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // Synchroniser shift and debounce counter: any sample equal to db restarts the count
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/button_step_gen.sv
// Converts two bouncing push-buttons into clean, mutually exclusive
// single-cycle inc/dec step pulses, with optional auto-repeat while held.
module button_step_gen
    import btn_step_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_dn_raw,
    input  logic repeat_en,
    output logic up_db,
    output logic dn_db,
    output logic inc,
    output logic dec
);

    localparam int TMR_MAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic up_db_w, dn_db_w;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up_deb (
        .clk (clk),
        .rst (rst),
        .raw (btn_up_raw),
        .db  (up_db_w)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn_deb (
        .clk (clk),
        .rst (rst),
        .raw (btn_dn_raw),
        .db  (dn_db_w)
    );

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             up_prev_q, up_prev_d;
    logic             dn_prev_q, dn_prev_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;

    logic up_rise, dn_rise;
    logic dir_btn, other_btn, hold_exit;

    assign up_rise   = up_db_w & ~up_prev_q;
    assign dn_rise   = dn_db_w & ~dn_prev_q;
    assign dir_btn   = (dir_q == DIR_DN) ? dn_db_w : up_db_w;
    assign other_btn = (dir_q == DIR_DN) ? up_db_w : dn_db_w;
    assign hold_exit = ~dir_btn | other_btn;

    // Next-state logic: press capture, hold delay, auto-repeat and release exit
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        timer_d   = timer_q;
        up_prev_d = up_db_w;
        dn_prev_d = dn_db_w;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_rise && !dn_db_w) begin
                    inc_d   = 1'b1;
                    dir_d   = DIR_UP;
                    timer_d = '0;
                    state_d = HOLD;
                end else if (dn_rise && !up_db_w) begin
                    dec_d   = 1'b1;
                    dir_d   = DIR_DN;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_exit) begin
                    state_d = IDLE;
                end else if (timer_q == HOLD_LAST) begin
                    if (repeat_en) begin
                        inc_d   = (dir_q == DIR_UP);
                        dec_d   = (dir_q == DIR_DN);
                        timer_d = '0;
                        state_d = REPEAT;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (hold_exit) begin
                    state_d = IDLE;
                end else if (!repeat_en) begin
                    timer_d = HOLD_LAST;
                    state_d = HOLD;
                end else if (timer_q == REP_LAST) begin
                    inc_d   = (dir_q == DIR_UP);
                    dec_d   = (dir_q == DIR_DN);
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered FSM, timer, edge-detect copies and output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            timer_q   <= '0;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            up_prev_q <= up_prev_d;
            dn_prev_q <= dn_prev_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
        end
    end

    assign up_db = up_db_w;
    assign dn_db = dn_db_w;
    assign inc   = inc_q;
    assign dec   = dec_q;

endmodule

// File: tb/tb_button_step_gen.sv
// Scoreboard bench for button_step_gen: stimulus pushes the expected pulse
// cycle and direction; a monitor pops and compares on every inc/dec pulse.
module tb_button_step_gen;
    import btn_step_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up_raw = 1'b0;
    logic btn_dn_raw = 1'b0;
    logic repeat_en = 1'b0;
    logic up_db, dn_db, inc, dec;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        logic is_dec;
    } exp_t;

    exp_t exp_q[$];

    button_step_gen #(
        .DEB_CYCLES    (4),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up_raw (btn_up_raw),
        .btn_dn_raw (btn_dn_raw),
        .repeat_en  (repeat_en),
        .up_db      (up_db),
        .dn_db      (dn_db),
        .inc        (inc),
        .dec        (dec)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k is visible from just after the k-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic up, input logic dn, input logic rep);
        btn_up_raw = up;
        btn_dn_raw = dn;
        repeat_en  = rep;
    endtask

    task automatic push_exp(input int c, input logic d);
        exp_t e;
        e.cyc    = c;
        e.is_dec = d;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: flag missed pulses, then match every observed pulse to the scoreboard
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missed_pulse: got none expected %s at cycle %0d",
                     exp_q[0].is_dec ? "dec" : "inc", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (inc || dec) begin
            checks++;
            if (inc && dec) begin
                errors++;
                $display("[TB] FAIL exclusive: got inc=1 dec=1 expected one at cycle %0d", cyc);
            end else if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: got %s at cycle %0d expected next at %0d",
                         inc ? "inc" : "dec", cyc,
                         (exp_q.size() > 0) ? exp_q[0].cyc : -1);
            end else begin
                if (exp_q[0].is_dec != dec) begin
                    errors++;
                    $display("[TB] FAIL pulse_dir: got %s expected %s at cycle %0d",
                             inc ? "inc" : "dec", exp_q[0].is_dec ? "dec" : "inc", cyc);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // Directed scenarios
    initial begin
        int t;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        wait_cycles(3);
        check_output("reset_up_db", up_db, 0);
        check_output("reset_dn_db", dn_db, 0);
        check_output("reset_inc", inc, 0);
        check_output("reset_dec", dec, 0);
        rst = 1'b0;
        wait_cycles(3);

        // 1: bouncing press, single inc 7 cycles after the last raw edge
        $display("[TB] scenario 1: bounce then hold, no repeat");
        apply_stimulus(1'b1, 1'b0, 1'b0); wait_cycles(2);
        apply_stimulus(1'b0, 1'b0, 1'b0); wait_cycles(2);
        apply_stimulus(1'b1, 1'b0, 1'b0); wait_cycles(2);
        apply_stimulus(1'b0, 1'b0, 1'b0); wait_cycles(2);
        t = cyc;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        push_exp(t + 7, 1'b0);
        wait_cycles(20);
        check_output("s1_up_db_high", up_db, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(15);
        check_output("s1_up_db_low", up_db, 0);

        // 2: short glitch never reaches the debounced level
        $display("[TB] scenario 2: 2-cycle glitch");
        apply_stimulus(1'b1, 1'b0, 1'b0); wait_cycles(2);
        apply_stimulus(1'b0, 1'b0, 1'b0); wait_cycles(4);
        check_output("s2_up_db_mid", up_db, 0);
        wait_cycles(8);
        check_output("s2_up_db_end", up_db, 0);

        // 3: down held with auto-repeat: +7, +15, then every 3 until release
        $display("[TB] scenario 3: down held with repeat");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(1);
        t = cyc;
        apply_stimulus(1'b0, 1'b1, 1'b1);
        push_exp(t + 7, 1'b1);
        for (int c = 15; c <= 45; c += 3) push_exp(t + c, 1'b1);
        wait_cycles(40);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(10);
        check_output("s3_dn_db_low", dn_db, 0);
        wait_cycles(10);

        // 4: up repeating, down pressed stops it; re-press up gives one inc
        $display("[TB] scenario 4: other button interrupts repeat");
        t = cyc;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        push_exp(t + 7, 1'b0);
        for (int c = 15; c <= 24; c += 3) push_exp(t + c, 1'b0);
        wait_cycles(20);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        wait_cycles(10);
        check_output("s4_both_db", {up_db, dn_db}, 3);
        check_output("s4_state_idle", int'(dut.state_q), int'(IDLE));
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(20);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        push_exp(t + 57, 1'b0);
        wait_cycles(10);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(15);

        // 5: simultaneous rises never pulse
        $display("[TB] scenario 5: simultaneous press");
        apply_stimulus(1'b1, 1'b1, 1'b1);
        wait_cycles(30);
        check_output("s5_both_db", {up_db, dn_db}, 3);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(15);

        // 6: reset during REPEAT, then a fresh debounced rise yields one inc
        $display("[TB] scenario 6: reset while repeating");
        t = cyc;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        push_exp(t + 7, 1'b0);
        push_exp(t + 15, 1'b0);
        push_exp(t + 18, 1'b0);
        wait_cycles(20);
        check_output("s6_state_repeat", int'(dut.state_q), int'(REPEAT));
        rst = 1'b1;
        wait_cycles(1);
        check_output("s6_rst_inc", inc, 0);
        check_output("s6_rst_up_db", up_db, 0);
        check_output("s6_rst_state", int'(dut.state_q), int'(IDLE));
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        push_exp(t + 28, 1'b0);
        wait_cycles(15);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(15);

        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL leftover_pulse: got none expected pulse at cycle %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
